// File: rtl/temp_pkg.sv
// Shared types, default widths and the saturation helper for the temperature scanner.
package temp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL,
    ADD,
    OUT
  } state_t;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_BASE_W   = 5;
  localparam int DEF_COEF_W   = 4;
  localparam int DEF_SENS_W   = 4;
  localparam int DEF_TEMP_W   = 8;
  localparam int DEF_ALARM_HI = 200;
  localparam int DEF_ALARM_LO = 150;

  // True when sum does not fit in temp_w bits and must be clipped to all ones.
  function automatic logic is_saturated(input logic [63:0] sum, input int unsigned temp_w);
    return (sum >> temp_w) != 64'd0;
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Sequential A_W x B_W unsigned multiplier: one multiplier bit per cycle, LSB first.
module shift_add_mul #(
  parameter int A_W = 4,
  parameter int B_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               done,
  output logic [A_W+B_W-1:0] product
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = $clog2(B_W + 1);

  logic [P_W-1:0]   mcand;
  logic [B_W-1:0]   mplier;
  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      product <= '0;
    end else if (start) begin
      mcand   <= P_W'(a);
      mplier  <= b;
      count   <= CNT_W'(B_W);
      product <= '0;
    end else if (count != '0) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - 1'b1;
    end
  end

  // Asserted during the final step so the caller can leave MUL on the same edge.
  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/temperature_scanner.sv
// Round-robin multi-channel temperature scanner: base + coef*sensor per channel,
// saturated, delivered on a valid/ready stream with per-channel hysteretic alarm.
module temperature_scanner
  import temp_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int BASE_W   = DEF_BASE_W,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int SENS_W   = DEF_SENS_W,
  parameter int TEMP_W   = DEF_TEMP_W,
  parameter int ALARM_HI = DEF_ALARM_HI,
  parameter int ALARM_LO = DEF_ALARM_LO
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      scanEn,
  input  logic [NUM_CH*BASE_W-1:0]  baseTemp,
  input  logic [NUM_CH*COEF_W-1:0]  tempCoef,
  input  logic [NUM_CH*SENS_W-1:0]  sensorVal,
  output logic                      outValid,
  input  logic                      outReady,
  output logic [$clog2(NUM_CH)-1:0] outCh,
  output logic [TEMP_W-1:0]         outTemp,
  output logic                      outSat,
  output logic [NUM_CH-1:0]         alarm,
  output logic                      busy
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int PROD_W = COEF_W + SENS_W;
  localparam int SUM_W  = BASE_W + PROD_W + 1;

  localparam logic [TEMP_W-1:0] HI_T = TEMP_W'(ALARM_HI);
  localparam logic [TEMP_W-1:0] LO_T = TEMP_W'(ALARM_LO);

  state_t state, state_nxt;

  logic [CH_W-1:0]   ptr;
  logic [BASE_W-1:0] base_q;
  logic [BASE_W-1:0] base_sel;
  logic [COEF_W-1:0] coef_sel;
  logic [SENS_W-1:0] sens_sel;
  logic              mul_start;
  logic              mul_done;
  logic [PROD_W-1:0] product;
  logic [SUM_W-1:0]  sum;
  logic              sat_flag;
  logic [TEMP_W-1:0] temp_sat;
  logic              accept;

  assign base_sel = baseTemp[int'(ptr)*BASE_W +: BASE_W];
  assign coef_sel = tempCoef[int'(ptr)*COEF_W +: COEF_W];
  assign sens_sel = sensorVal[int'(ptr)*SENS_W +: SENS_W];

  assign outValid  = (state == OUT);
  assign busy      = (state != IDLE);
  assign accept    = outValid & outReady;
  assign mul_start = (state == LOAD);

  // Coefficient and sensor are captured inside the multiplier on start; base is held here.
  shift_add_mul #(
    .A_W(COEF_W),
    .B_W(SENS_W)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start),
    .a      (coef_sel),
    .b      (sens_sel),
    .done   (mul_done),
    .product(product)
  );

  assign sum      = SUM_W'(base_q) + SUM_W'(product);
  assign sat_flag = is_saturated(64'(sum), TEMP_W);
  assign temp_sat = sat_flag ? '1 : sum[TEMP_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (scanEn) state_nxt = LOAD;
      LOAD:    state_nxt = MUL;
      MUL:     if (mul_done) state_nxt = ADD;
      ADD:     state_nxt = OUT;
      OUT:     if (outReady) state_nxt = scanEn ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      base_q  <= '0;
      outCh   <= '0;
      outTemp <= '0;
      outSat  <= 1'b0;
      alarm   <= '0;
    end else begin
      if (state == LOAD) base_q <= base_sel;

      if (state == ADD) begin
        outTemp <= temp_sat;
        outSat  <= sat_flag;
        outCh   <= ptr;
        // Hysteresis band between LO_T and HI_T leaves the flag as it was.
        if (temp_sat >= HI_T)      alarm[ptr] <= 1'b1;
        else if (temp_sat <= LO_T) alarm[ptr] <= 1'b0;
      end

      if (accept) ptr <= (ptr == CH_W'(NUM_CH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule
